// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/sender state encoding and default link parameters.
package uart_pkg;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} uart_state_e;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop rxd synchronizer plus 3-sample majority vote, all resetting to idle-high.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk_sample,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s,
  output logic vote
);
  logic [1:0] sync_q, sync_d, hist_q, hist_d;
  always_comb begin
    sync_d = {sync_q[0], rxd};
    hist_d = {hist_q[0], sync_q[1]};
  end
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      hist_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end
  assign rxd_s = sync_q[1];
  // vote covers the current rxd_s and the two cycles before it
  assign vote = maj3(sync_q[1], hist_q[0], hist_q[1]);
endmodule

// File: rtl/uart_recv.sv
// uart_recv: oversampled 8N1 UART receiver with framing check; 8E1 with parity check
// when UART_RECV_PARITY_EN is defined.
module uart_recv
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk_sample,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 recv_over,
  output logic                 frame_err,
  output logic                 parity_err
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_VOTE = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
`ifdef UART_RECV_PARITY_EN
  localparam uart_state_e AFTER_DATA = PARITY;
`else
  localparam uart_state_e AFTER_DATA = STOP;
`endif
  logic rxd_s, vote, at_vote, bit_end;
  uart_state_e state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bidx_q, bidx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, dout_q, dout_d;
  logic recv_over_q, recv_over_d, frame_err_q, frame_err_d;
  uart_rx_sync u_sync (
    .clk_sample(clk_sample),
    .rst       (rst),
    .rxd       (rxd),
    .rxd_s     (rxd_s),
    .vote      (vote)
  );
  assign at_vote = tick_q == T_VOTE;
  assign bit_end = tick_q == T_LAST;
  always_comb begin
    state_d = state_q;
    tick_d = bit_end ? '0 : tick_q + 1'b1;
    bidx_d = bidx_q;
    shift_d = shift_q;
    dout_d = dout_q;
    recv_over_d = 1'b0;
    frame_err_d = frame_err_q;
    case (state_q)
      IDLE: begin
        // the detecting cycle is tick 0 of the start bit
        tick_d = rxd_s ? '0 : TW'(1);
        state_d = rxd_s ? IDLE : START;
      end
      START: state_d = (at_vote && vote) ? IDLE : bit_end ? DATA : START;
      DATA: begin
        if (at_vote) shift_d[bidx_q] = vote;
        if (bit_end) begin
          bidx_d = bidx_q == B_LAST ? '0 : bidx_q + 1'b1;
          state_d = bidx_q == B_LAST ? AFTER_DATA : DATA;
        end
      end
`ifdef UART_RECV_PARITY_EN
      PARITY: state_d = bit_end ? STOP : PARITY;
`endif
      STOP: if (at_vote) begin
        dout_d = shift_q;
        frame_err_d = ~vote;
        recv_over_d = 1'b1;
        // leave early on a good stop bit so a slightly fast sender is tolerated
        state_d = vote ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        tick_d = '0;
        state_d = rxd_s ? IDLE : WAIT_HIGH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q <= '0;
      bidx_q <= '0;
      shift_q <= '0;
      dout_q <= '0;
      recv_over_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      bidx_q <= bidx_d;
      shift_q <= shift_d;
      dout_q <= dout_d;
      recv_over_q <= recv_over_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign dout = dout_q;
  assign recv_over = recv_over_q;
  assign frame_err = frame_err_q;
`ifdef UART_RECV_PARITY_EN
  logic par_q, par_d, parity_err_q, parity_err_d;
  always_comb begin
    par_d = (state_q == PARITY && at_vote) ? vote ^ (^shift_q) : par_q;
    parity_err_d = (state_q == STOP && at_vote) ? par_q : parity_err_q;
  end
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q <= par_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: directed bench for uart_recv with hand-computed bytes, flags and strobe timing.
module tb_uart_recv;
  import uart_pkg::*;
`ifdef UART_RECV_PARITY_EN
  localparam int LAT = 172;
  localparam int FRAME = 176;
  logic bad_par = 1'b0;
`else
  localparam int LAT = 156;
  localparam int FRAME = 160;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic [7:0] dout;
  logic recv_over, frame_err, parity_err;
  int edges = 0;
  int n_strobe = 0;
  int last_edge = 0, prev_edge = 0;
  logic [7:0] last_dout = '0, prev_dout = '0;
  logic last_fe = 1'b0, prev_fe = 1'b0;
  int n_checks = 0, n_fail = 0;
  int n0, e0;

  uart_recv dut (
    .clk_sample(clk),
    .rst       (rst),
    .rxd       (rxd),
    .dout      (dout),
    .recv_over (recv_over),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;
  always @(negedge clk) if (recv_over) begin
    n_strobe <= n_strobe + 1;
    prev_edge <= last_edge;
    last_edge <= edges;
    prev_dout <= last_dout;
    last_dout <= dout;
    prev_fe <= last_fe;
    last_fe <= frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    idle(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RECV_PARITY_EN
    send_bit((^d) ^ bad_par);
`endif
    send_bit(stop);
  endtask

  initial begin
    idle(3);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_recv_over", 32'(recv_over), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    idle(5);
    // single frame 0x4A
    n0 = n_strobe;
    e0 = edges;
    send_frame(8'h4A, 1'b1);
    idle(20);
    check("t1_strobes", 32'(n_strobe), 32'(n0 + 1));
    check("t1_latency", 32'(last_edge - e0), 32'(LAT));
    check("t1_dout", 32'(dout), 32'h4A);
    check("t1_frame_err", 32'(frame_err), 32'h0);
    check("t1_parity_err", 32'(parity_err), 32'h0);
    // back-to-back 0x55, 0xAA
    n0 = n_strobe;
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    idle(20);
    check("t2_strobes", 32'(n_strobe), 32'(n0 + 2));
    check("t2_spacing", 32'(last_edge - prev_edge), 32'(FRAME));
    check("t2_first_dout", 32'(prev_dout), 32'h55);
    check("t2_first_fe", 32'(prev_fe), 32'h0);
    check("t2_dout", 32'(dout), 32'hAA);
    check("t2_frame_err", 32'(frame_err), 32'h0);
    // 3-cycle glitch
    n0 = n_strobe;
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(8);
    check("t3_state_c9", 32'(dut.state_q), 32'(START));
    idle(1);
    check("t3_state_c10", 32'(dut.state_q), 32'(IDLE));
    idle(30);
    check("t3_strobes", 32'(n_strobe), 32'(n0));
    check("t3_dout", 32'(dout), 32'hAA);
    // bad stop bit followed by a long break
    n0 = n_strobe;
    send_frame(8'h3C, 1'b0);
    idle(640);
    check("t4_strobes", 32'(n_strobe), 32'(n0 + 1));
    check("t4_dout", 32'(dout), 32'h3C);
    check("t4_frame_err", 32'(frame_err), 32'h1);
    rxd = 1'b1;
    idle(32);
    send_frame(8'h81, 1'b1);
    idle(20);
    check("t4_strobes_after", 32'(n_strobe), 32'(n0 + 2));
    check("t4_dout_after", 32'(dout), 32'h81);
    check("t4_frame_err_after", 32'(frame_err), 32'h0);
    // reset during data bit 4
    n0 = n_strobe;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rxd = 1'b1;
    idle(8);
    rst = 1'b1;
    #1;
    check("t5_rst_dout", 32'(dout), 32'h0);
    check("t5_rst_recv_over", 32'(recv_over), 32'h0);
    check("t5_rst_frame_err", 32'(frame_err), 32'h0);
    check("t5_rst_state", 32'(dut.state_q), 32'(IDLE));
    idle(2);
    rst = 1'b0;
    idle(200);
    check("t5_no_strobe", 32'(n_strobe), 32'(n0));
    e0 = edges;
    send_frame(8'hF0, 1'b1);
    idle(20);
    check("t5_strobes", 32'(n_strobe), 32'(n0 + 1));
    check("t5_latency", 32'(last_edge - e0), 32'(LAT));
    check("t5_dout", 32'(dout), 32'hF0);
`ifdef UART_RECV_PARITY_EN
    e0 = edges;
    bad_par = 1'b0;
    send_frame(8'h07, 1'b1);
    idle(20);
    check("t6_latency", 32'(last_edge - e0), 32'd172);
    check("t6_dout", 32'(dout), 32'h07);
    check("t6_parity_err", 32'(parity_err), 32'h0);
    bad_par = 1'b1;
    send_frame(8'h07, 1'b1);
    idle(20);
    check("t6_bad_parity_err", 32'(parity_err), 32'h1);
    check("t6_bad_frame_err", 32'(frame_err), 32'h0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_recv.md
# uart_recv

RS-422 UART receiver; the receive-side counterpart of `uart_send` on the same link. It runs entirely on the 16x oversampling clock `clk_sample`. It recovers 8N1 frames from `rxd` (LSB first), presents each byte on `dout` with a one-cycle `recv_over` strobe, and flags framing errors. It sits between the RS-422 line receiver and the byte-consuming logic.

## Interface
- `OVERSAMPLE`, default 16: `clk_sample` cycles per bit. Must be ≥ 8 and even.
- `DATA_BITS`, default 8: data bits per frame.
- `clk_sample` in 1: oversampling clock, 16x the baud rate.
- `rst` in 1: reset, asynchronous, active-high.
- `rxd` in 1: serial line. Asynchronous; idles high.
- `dout` out `DATA_BITS`: last received byte. Held until the next frame completes.
- `recv_over` out 1: one-cycle pulse when a frame completes, whether good or bad.
- `frame_err` out 1: stop bit sampled low. Valid with `recv_over` and held until the next `recv_over`.
- `parity_err` out 1: parity mismatch. Valid with `recv_over` and held. Tied 0 when parity is compiled out.

## Operation
- `rxd` passes through a 2-flop synchronizer. Both flops reset to 1. The output of the second flop is `rxd_s`.
- Bit timer `tick` counts 0..`OVERSAMPLE`-1. Bit index `bidx` counts 0..`DATA_BITS`-1.
- Each bit is decided by a 2-of-3 majority vote of `rxd_s` taken at ticks M-1, M and M+1, where M = `OVERSAMPLE`/2. The decision is made at tick M+1.
- States:
  - IDLE: the first cycle with `rxd_s`=0 → START with tick=0.
  - START: at tick M+1, a vote of 1 is a glitch → IDLE with no strobe. A vote of 0 → DATA at the end of the bit.
  - DATA: each vote is shifted into bit position `bidx`, LSB first. After the last bit → PARITY if enabled, otherwise STOP.
  - PARITY: the vote is compared against even parity of the data bits → STOP.
  - STOP: at tick M+1, load `dout`, set `frame_err` to the inverse of the vote, and pulse `recv_over` on the next cycle.
    - Vote 1 → IDLE immediately. The rest of the stop bit is not waited out, so the receiver tolerates a faster transmitter.
    - Vote 0 → WAIT_HIGH.
  - WAIT_HIGH: stays until `rxd_s`=1, then → IDLE. A held-low line (break) therefore produces exactly one error frame.
- A new start edge is accepted on the first IDLE cycle after STOP.
- The shift register is separate from `dout`. `dout` changes only on the cycle `recv_over` rises.

## Timing
- Reset values:
  - `dout` = 0.
  - `recv_over` = 0.
  - `frame_err` = 0.
  - `parity_err` = 0.
  - State = IDLE; tick = 0; bidx = 0.
  - Synchronizer flops = 1.
- Latency with OVERSAMPLE=16, 8N1: cycle 0 is the cycle where IDLE sees `rxd_s`=0. `recv_over` is high in cycle 9·16+9+1 = 154. From an `rxd` pin transition this is 156 cycles.
- Parity enabled: add 16 cycles.
- `recv_over` is exactly one cycle wide. `dout` and the error flags are stable from that cycle until the next strobe.
- Reset asserted mid-frame: all outputs and state return to reset values asynchronously. No strobe is issued for the aborted frame.
- A low pulse shorter than 2 of the 3 vote samples at the start-bit centre → IDLE with no output change.

## Configuration
- `UART_RECV_PARITY_EN` defined:
  - Frames are 8E1: an even-parity bit follows the data bits, using the PARITY state.
  - `parity_err` = 1 when the parity vote ≠ XOR of the data bits.
- `UART_RECV_PARITY_EN` undefined:
  - The PARITY state and its logic are absent; frames are 8N1.
  - `parity_err` is a constant 0.

## Structure
- Shared package `uart_pkg`:
  - State enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - Default OVERSAMPLE and DATA_BITS constants, shared with `uart_send`.
- Sub-module `uart_rx_sync`:
  - Contains the 2-flop synchronizer plus the 3-sample majority shift register.
  - Outputs `rxd_s` and `vote`.
  - Is resettable to 1.
- The FSM, timers and shift register are in `uart_recv`.

## Test plan
- Send 0x4A as 8N1 at 16 cycles/bit (line: 0, 0,1,0,1,0,0,1,0, 1) → `recv_over` pulses once at cycle 154, `dout`=8'h4A, `frame_err`=0.
- Back-to-back frames 0x55 then 0xAA, with the second start bit immediately after a 16-cycle stop bit → two strobes 160 cycles apart, `dout` values 8'h55 then 8'hAA, no errors.
- 3-cycle low glitch on an idle line → no `recv_over`; `dout` unchanged; the FSM is back in IDLE by cycle 10.
- Frame 0x3C with stop bit 0, then the line held low for 40 bit times → exactly one `recv_over`, `dout`=8'h3C, `frame_err`=1. The next valid 0x81 after the line returns high → `dout`=8'h81, `frame_err`=0.
- `rst` pulsed high during data bit 4 of a frame, then a full 0xF0 frame → no strobe for the aborted frame; outputs read 0 during reset; the following frame gives `dout`=8'hF0.
- With `UART_RECV_PARITY_EN`:
  - 0x07 with parity bit 1 → `parity_err`=0, strobe at cycle 170.
  - The same frame with parity bit 0 → `parity_err`=1.
